// File: rtl/sdram_frame_pkg.sv
// Shared types and helpers for the SDRAM frame reader and its FIFO.
package sdram_frame_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] FullCount = (AW + 1)'(Depth);
  localparam logic [AW:0] CntOne    = 1;
  localparam logic [AW-1:0] PtrOne  = 1;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              push, pop;

  assign push      = wr_en_i;
  // Pop is ignored while empty, so a push into an empty FIFO never bypasses.
  assign pop       = rd_en_i && !empty_o;
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      count_q <= count_q + CntOne;
      else if (!push && pop) count_q <= count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(push && count_q == FullCount));
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM pipelined read master streaming an RGB332 frame from SDRAM to a pixel stream.
module sdram_frame_reader
  import sdram_frame_pkg::*;
#(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned FIFO_AW   = 6
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [7:0]        avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              underflow
);

  localparam int unsigned FramePix = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam int unsigned IssW     = $clog2(FramePix + 1);
  localparam int unsigned ColW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LineW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [FIFO_AW:0] Depth    = (FIFO_AW + 1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] CntOne   = 1;
  localparam logic [IssW-1:0]  FrameCnt = IssW'(FramePix);
  localparam logic [IssW-1:0]  LastIss  = IssW'(FramePix - 1);
  localparam logic [IssW-1:0]  IssOne   = 1;
  localparam logic [ADDR_W-1:0] Base    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrOne = 1;
  localparam logic [ColW-1:0]  LastCol  = ColW'(H_ACTIVE - 1);
  localparam logic [ColW-1:0]  ColOne   = 1;
  localparam logic [LineW-1:0] LastLine = LineW'(V_ACTIVE - 1);
  localparam logic [LineW-1:0] LineOne  = 1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [IssW-1:0]    issued_q;
  logic [FIFO_AW:0]   pending_q, fifo_count, inflight;
  logic [ColW-1:0]    col_q;
  logic [LineW-1:0]   line_q;
  logic               stall_q, underflow_q;
  logic               fifo_empty, fetch_ok, accept, pop, start;
  rgb332_t            head;

  // Credit covers both buffered and in-flight bytes so returns can never overflow.
  assign inflight = fifo_count + pending_q;
  assign fetch_ok = (state_q == FETCH) && (inflight < Depth) && (issued_q < FrameCnt);
  // A stalled request stays up even if enable drops; no retraction on the bus.
  assign avm_read    = fetch_ok && (enable || stall_q);
  assign avm_address = addr_q;
  assign accept      = avm_read && !avm_waitrequest;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = pix_valid ? head : 8'h00;
  assign pix_sof   = pix_valid && (col_q == '0) && (line_q == '0);
  assign pix_eol   = pix_valid && (col_q == LastCol);
  assign busy      = (state_q != IDLE) || (pending_q != '0);
  assign underflow = underflow_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          start   = 1'b1;
        end
      end
      FETCH: begin
        if (accept && issued_q == LastIss)          state_d = DRAIN;
        else if (!enable && (!avm_read || accept)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pending_q == '0) begin
          state_d = enable ? FETCH : IDLE;
          start   = enable;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      addr_q      <= Base;
      issued_q    <= '0;
      pending_q   <= '0;
      stall_q     <= 1'b0;
      underflow_q <= 1'b0;
      col_q       <= '0;
      line_q      <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= avm_read && avm_waitrequest;
      if (start) begin
        addr_q   <= Base;
        issued_q <= '0;
      end else if (accept) begin
        addr_q   <= addr_q + AddrOne;
        issued_q <= issued_q + IssOne;
      end
      if (accept && !avm_readdatavalid)      pending_q <= pending_q + CntOne;
      else if (!accept && avm_readdatavalid) pending_q <= pending_q - CntOne;
      if (state_q == FETCH && pix_ready && fifo_empty) underflow_q <= 1'b1;
      if (pop) begin
        if (col_q == LastCol) begin
          col_q  <= '0;
          line_q <= (line_q == LastLine) ? '0 : line_q + LineOne;
        end else begin
          col_q <= col_q + ColOne;
        end
      end
    end
  end

  sync_fifo_fwft #(
    .DATA_W(8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i    (clk_clk),
    .rst_i    (reset_reset),
    .wr_en_i  (avm_readdatavalid),
    .wr_data_i(avm_readdata),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench: memory model returns address bytes; expected pixels queued at request accept.
module tb_sdram_frame_reader;
  import sdram_frame_pkg::*;

  localparam int H     = 4;
  localparam int V     = 32;
  localparam int FRAME = H * V;
  localparam int BASE  = 0;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        enable = 1'b0;
  logic [22:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [7:0]  avm_readdata = 8'h00;
  logic        avm_readdatavalid = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_sof, pix_eol, busy, underflow;

  always #5 clk_clk = ~clk_clk;

  sdram_frame_reader #(
    .ADDR_W   (23),
    .BASE_ADDR(BASE),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FIFO_AW  (6)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .enable           (enable),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_sof          (pix_sof),
    .pix_eol          (pix_eol),
    .busy             (busy),
    .underflow        (underflow)
  );

  typedef struct { int due; logic [7:0] d; } rd_t;
  typedef struct { logic [7:0] d; bit sof; bit eol; } px_t;

  rd_t mem_q[$];
  px_t exp_q[$];
  px_t mon_p;
  int  mon_pos;

  int tests = 0, fails = 0;
  int cyc = 0, lat = 3, ready_pct = 100;
  int acc_cnt = 0, acc_frame = 0, pop_cnt = 0, push_cnt = 0;
  int hold_after = 0, drop_after = 0;
  bit rand_wr = 0;
  bit prev_stall = 0;
  logic [22:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: bus protocol, memory model bookkeeping and pixel scoreboard.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (prev_stall) begin
        check("stall_hold_read", avm_read, 1);
        check("stall_hold_addr", avm_address, prev_addr);
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (avm_readdatavalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (avm_read && !avm_waitrequest) begin
        check("req_addr", avm_address, BASE + acc_frame);
        mem_q.push_back('{due: cyc + lat, d: avm_address[7:0]});
        mon_pos = push_cnt % FRAME;
        exp_q.push_back('{d: 8'((BASE + acc_frame) & 255), sof: (mon_pos == 0),
                          eol: ((mon_pos % H) == H - 1)});
        push_cnt++;
        acc_cnt++;
        acc_frame = (acc_frame + 1) % FRAME;
      end
      if (pix_valid && pix_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pix_unexpected: got %02h expected none", pix_data);
        end else begin
          mon_p = exp_q.pop_front();
          check("pix_sof_eol_data", {22'd0, pix_sof, pix_eol, pix_data},
                {22'd0, mon_p.sof, mon_p.eol, mon_p.d});
        end
      end
    end
  end

  // Driver: slave responses and consumer ready, updated just after each rising edge.
  always @(posedge clk_clk) begin
    #1;
    cyc++;
    if (drop_after > 0 && acc_cnt >= drop_after) enable = 1'b0;
    if (hold_after > 0 && acc_cnt >= hold_after) avm_waitrequest = 1'b1;
    else avm_waitrequest = rand_wr ? ($urandom_range(0, 1) == 1) : 1'b0;
    pix_ready = ($urandom_range(0, 99) < ready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_q[0].d;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 8'($urandom);
    end
  end

  task automatic clear_model();
    enable = 1'b0; drop_after = 0; hold_after = 0; rand_wr = 0;
    mem_q.delete(); exp_q.delete();
    acc_cnt = 0; acc_frame = 0; pop_cnt = 0; push_cnt = 0; prev_stall = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_read"}, avm_read, 0);
    check({name, "_addr"}, avm_address, BASE);
    check({name, "_outs"}, {pix_valid, pix_data, pix_sof, pix_eol, busy, underflow}, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk_clk); #3;
    reset_reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk_clk);
    #3 reset_reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pop_cnt < n && k < budget) begin @(negedge clk_clk); k++; end
    check(name, pop_cnt >= n, 1);
  endtask

  task automatic stop_and_idle(input string name);
    int k = 0;
    @(posedge clk_clk); #3 enable = 1'b0;
    while (busy && k < 500) begin @(negedge clk_clk); k++; end
    check(name, busy, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk_clk);
    #3 check_all_zero("reset");
    reset_reset = 1'b0;

    // Continuous stream with ready high: two frame starts, eol every H pixels.
    lat = 3; ready_pct = 100;
    @(posedge clk_clk); #3 enable = 1'b1;
    @(negedge clk_clk); check("lat_idle_read", avm_read, 0);
    @(negedge clk_clk); check("lat_first_read", avm_read, 1);
    k = 0;
    while (!avm_readdatavalid && k < 50) begin @(negedge clk_clk); k++; end
    check("valid_before_write", pix_valid, 0);
    @(negedge clk_clk); check("valid_after_write", pix_valid, 1);
    wait_pops(FRAME + 8, 3000, "t1_stream");
    stop_and_idle("t1_idle");
    pulse_reset();

    // Consumer stalled: credit limits reads to the FIFO depth.
    ready_pct = 0; lat = 3;
    @(posedge clk_clk); #3 enable = 1'b1;
    repeat (200) @(negedge clk_clk);
    check("credit_accepts", acc_cnt, 64);
    check("credit_read_low", avm_read, 0);
    check("credit_pending", dut.pending_q, 0);
    check("credit_fifo_count", dut.fifo_count, 64);
    check("credit_valid", pix_valid, 1);
    ready_pct = 100;
    wait_pops(FRAME, 3000, "t2_frame");
    stop_and_idle("t2_idle");
    pulse_reset();

    // Random slave stalls and random consumer backpressure.
    rand_wr = 1; ready_pct = 70; lat = 4;
    @(posedge clk_clk); #3 enable = 1'b1;
    wait_pops(FRAME, 6000, "t3_frame");
    stop_and_idle("t3_idle");
    pulse_reset();

    // Enable dropped after five accepted requests.
    ready_pct = 100; lat = 3; drop_after = 5;
    @(posedge clk_clk); #3 enable = 1'b1;
    repeat (40) @(negedge clk_clk);
    check("drop_accepts", acc_cnt, 5);
    check("drop_pixels", pop_cnt, 5);
    check("drop_busy", busy, 0);
    check("drop_state", dut.state_q, IDLE);
    pulse_reset();

    // Asynchronous reset with three reads outstanding, then restart.
    lat = 10; hold_after = 3;
    @(posedge clk_clk); #3 enable = 1'b1;
    k = 0;
    while (acc_cnt < 3 && k < 50) begin @(negedge clk_clk); k++; end
    repeat (2) @(negedge clk_clk);
    check("rst_pending", dut.pending_q, 3);
    @(posedge clk_clk); #3 reset_reset = 1'b1;
    #1 check_all_zero("async_rst");
    clear_model();
    repeat (2) @(posedge clk_clk);
    #3 reset_reset = 1'b0;
    lat = 3;
    enable = 1'b1;
    wait_pops(8, 300, "t5_restart");
    stop_and_idle("t5_idle");
    pulse_reset();

    // Slow memory with ready high from the start: sticky underflow.
    lat = 10; ready_pct = 100;
    @(posedge clk_clk); #3 enable = 1'b1;
    @(negedge clk_clk); check("uf_idle", underflow, 0);
    repeat (5) @(negedge clk_clk);
    check("uf_set", underflow, 1);
    repeat (100) @(negedge clk_clk);
    check("uf_sticky", underflow, 1);
    check("uf_flowing", pop_cnt > 0, 1);
    pulse_reset();
    @(negedge clk_clk); check("uf_cleared", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
